// File: rtl/ppu_pkg.sv
// Shared widths, saturation bounds, per-beat config type and clamp helper
// for the ppu_vec post-processing pipeline.
package ppu_pkg;

   localparam int IN_W    = 32;
   localparam int OUT_W   = 8;
   localparam int MULT_W  = 16;
   localparam int SHIFT_W = 6;

   // Full-precision product width: signed IN_W times zero-extended MULT_W.
   localparam int PROD_W  = IN_W + MULT_W + 1;

   // Clamp bounds expressed at product width so comparisons stay signed.
   localparam logic signed [PROD_W-1:0] SAT_SMAX = PROD_W'(2**(OUT_W-1) - 1);
   localparam logic signed [PROD_W-1:0] SAT_SMIN = PROD_W'(-(2**(OUT_W-1)));
   localparam logic signed [PROD_W-1:0] SAT_UMAX = PROD_W'(2**OUT_W - 1);

   // Requant config captured with each accepted beat and carried down the pipe.
   typedef struct packed {
      logic [MULT_W-1:0]  mult;
      logic [SHIFT_W-1:0] shift;
      logic               relu_en;
   } ppu_cfg_t;

   typedef struct packed {
      logic [OUT_W-1:0] q;
      logic             sat;
   } sat_res_t;

   // Clamp a shifted product to OUT_W bits; unsigned range when relu_en.
   function automatic sat_res_t sat_clamp(input logic signed [PROD_W-1:0] value,
                                          input logic relu_en);
      sat_res_t r;
      r.q   = value[OUT_W-1:0];
      r.sat = 1'b0;
      if (relu_en) begin
         if (value > SAT_UMAX) begin
            r.q   = SAT_UMAX[OUT_W-1:0];
            r.sat = 1'b1;
         end else if (value < 0) begin
            r.q   = '0;
            r.sat = 1'b1;
         end
      end else begin
         if (value > SAT_SMAX) begin
            r.q   = SAT_SMAX[OUT_W-1:0];
            r.sat = 1'b1;
         end else if (value < SAT_SMIN) begin
            r.q   = SAT_SMIN[OUT_W-1:0];
            r.sat = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ppu_lane.sv
// One lane of the ppu_vec datapath: ReLU (S1), full-precision multiply (S2),
// shift / optional rounding / clamp (S3). Stage enables come from the parent.
// Rounding half away from zero is built in when PPU_ROUND_EN is defined.
module ppu_lane
   import ppu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               en1,
   input  logic               en2,
   input  logic               en3,
   input  logic [IN_W-1:0]    lane_in,
   input  logic               relu_in,
   input  logic [MULT_W-1:0]  mult_s1,
   input  logic [SHIFT_W-1:0] shift_s2,
   input  logic               relu_s2,
   output logic [OUT_W-1:0]   q,
   output logic               sat
);

   logic signed [IN_W-1:0]   s1_val;
   logic signed [PROD_W-1:0] s2_prod;
   logic signed [PROD_W-1:0] shifted;
   sat_res_t                 clamp;

   // S1: zero negative lanes when ReLU is enabled for this beat.
   always_ff @(posedge clk) begin
      if (en1) s1_val <= (relu_in && lane_in[IN_W-1]) ? '0 : $signed(lane_in);
   end

   // S2: exact signed product, multiplier treated as unsigned.
   always_ff @(posedge clk) begin
      if (en2) s2_prod <= $signed({{(MULT_W+1){s1_val[IN_W-1]}}, s1_val}) *
                          $signed({{(IN_W+1){1'b0}}, mult_s1});
   end

`ifdef PPU_ROUND_EN
   logic signed [PROD_W-1:0] bias;

   // S3 combinational: add the half-LSB bias (one less for negatives), then shift.
   always_comb begin
      bias = '0;
      if (shift_s2 != '0) begin
         bias = PROD_W'(1) << (shift_s2 - SHIFT_W'(1));
         if (s2_prod[PROD_W-1]) bias = bias - PROD_W'(1);
      end
      shifted = (s2_prod + bias) >>> shift_s2;
      clamp   = sat_clamp(shifted, relu_s2);
   end
`else
   // S3 combinational: floor via arithmetic shift, then clamp.
   always_comb begin
      shifted = s2_prod >>> shift_s2;
      clamp   = sat_clamp(shifted, relu_s2);
   end
`endif

   // S3 register: quantized lane value and its per-beat saturation bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         q   <= '0;
         sat <= 1'b0;
      end else if (en3) begin
         q   <= clamp.q;
         sat <= clamp.sat;
      end
   end

endmodule

// File: rtl/ppu_vec.sv
// ppu_vec: LANES-wide, 3-stage requantization pipeline (ReLU, multiply,
// shift+clamp) with valid/ready on both sides and sticky saturation flags.
// Optional macro PPU_ROUND_EN selects round-half-away-from-zero before the shift.
//
// Handshake: a beat moves when valid && ready at a rising clk edge. A stage
// loads when it is empty or its downstream stage is moving; in_ready is that
// condition for S1, combinational from out_ready. out_valid/out_data hold
// until accepted.
module ppu_vec
   import ppu_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*IN_W-1:0]  in_data,
   input  logic [MULT_W-1:0]      cfg_mult,
   input  logic [SHIFT_W-1:0]     cfg_shift,
   input  logic                   cfg_relu_en,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] out_data,
   output logic [LANES-1:0]       sat_flags,
   input  logic                   sat_clr
);

   logic v1, v2, v3;
   logic adv1, adv2, adv3;
   logic fire;
   ppu_cfg_t           cfg1;
   logic [SHIFT_W-1:0] shift2;
   logic               relu2;
   logic [LANES-1:0]   lane_sat;

   // Backpressure chain: each stage moves if empty or if downstream moves.
   always_comb begin
      adv3 = !v3 || out_ready;
      adv2 = !v2 || adv3;
      adv1 = !v1 || adv2;
   end

   assign in_ready  = adv1;
   assign out_valid = v3;
   assign fire      = v3 && out_ready;

   // Stage valid bits; reset drops every in-flight beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         if (adv1) v1 <= in_valid;
         if (adv2) v2 <= v1;
         if (adv3) v3 <= v2;
      end
   end

   // Per-beat config travels with its data so in-flight beats are unaffected.
   always_ff @(posedge clk) begin
      if (adv1) cfg1 <= '{mult: cfg_mult, shift: cfg_shift, relu_en: cfg_relu_en};
      if (adv2) begin
         shift2 <= cfg1.shift;
         relu2  <= cfg1.relu_en;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      ppu_lane u_lane (
         .clk      (clk),
         .rst      (rst),
         .en1      (adv1),
         .en2      (adv2),
         .en3      (adv3),
         .lane_in  (in_data[i*IN_W +: IN_W]),
         .relu_in  (cfg_relu_en),
         .mult_s1  (cfg1.mult),
         .shift_s2 (shift2),
         .relu_s2  (relu2),
         .q        (out_data[i*OUT_W +: OUT_W]),
         .sat      (lane_sat[i])
      );
   end

   // Sticky saturation: set on output handshake (wins over clear), else sat_clr clears.
   always_ff @(posedge clk) begin
      if (rst) sat_flags <= '0;
      else     sat_flags <= (fire ? lane_sat : '0) | (sat_flags & {LANES{~sat_clr}});
   end

   // Shift amounts of IN_W+MULT_W or more have no defined result.
   always @(posedge clk) begin
      if (!rst && in_valid && in_ready) assert ({1'b0, cfg_shift} < 7'(IN_W + MULT_W));
   end

endmodule

// File: tb/tb_ppu_vec.sv
// Self-checking bench for ppu_vec: vector table, hand sequences for
// saturation / backpressure / reset, and randomized beats against a model.
module tb_ppu_vec;
  import ppu_pkg::*;

  localparam int LANES = 4;
  localparam int DW = LANES * IN_W;
  localparam int QW = LANES * OUT_W;
`ifdef PPU_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DW-1:0] in_data = '0;
  logic [MULT_W-1:0] cfg_mult = '0;
  logic [SHIFT_W-1:0] cfg_shift = '0;
  logic cfg_relu_en = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [QW-1:0] out_data;
  logic [LANES-1:0] sat_flags;
  logic sat_clr = 1'b0;

  ppu_vec #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
    .cfg_relu_en(cfg_relu_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat_flags(sat_flags), .sat_clr(sat_clr)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int failures = 0;
  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] cur_exp = '0;
  int rdy_mode = 0;
  int phase = 0;
  int seen = 0;
  bit stalled = 1'b0;
  logic [QW-1:0] held = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] pack_i(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  function automatic logic [QW-1:0] pack_o(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // reference model: real arithmetic on 64-bit integers
  function automatic logic [QW-1:0] model(input logic [DW-1:0] d, input int unsigned mult,
                                          input int unsigned shift, input bit relu);
    logic [QW-1:0] r;
    logic [IN_W-1:0] raw;
    longint v, p, qv, lo, hi;
    r = '0;
    lo = relu ? 0 : -(longint'(1) << (OUT_W - 1));
    hi = relu ? (longint'(1) << OUT_W) - 1 : (longint'(1) << (OUT_W - 1)) - 1;
    for (int i = 0; i < LANES; i++) begin
      raw = d[i*IN_W +: IN_W];
      v = longint'($signed(raw));
      if (relu && v < 0) v = 0;
      p = v * longint'(mult);
      if (RND && shift > 0) p = p + ((p >= 0) ? (longint'(1) << (shift - 1))
                                              : (longint'(1) << (shift - 1)) - 1);
      qv = p >>> shift;
      if (qv > hi) qv = hi;
      if (qv < lo) qv = lo;
      r[i*OUT_W +: OUT_W] = qv[OUT_W-1:0];
    end
    return r;
  endfunction

  // out_ready driver: 0 = high, 1 = pattern 1,0,0,1, 2 = random, 3 = low
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (phase % 4 == 0) || (phase % 4 == 3);
        phase++;
      end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // scoreboard: stability / full-stall checks, output pops, input pushes
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid_hold", 128'(out_valid), 128'(1));
        chk("stall_data_hold", 128'(out_data), 128'(held));
      end
      if (out_valid && !out_ready && exp_q.size() >= 3)
        chk("in_ready_low_full", 128'(in_ready), 128'(0));
      stalled = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", out_data);
        end else begin
          chk("beat_data", 128'(out_data), 128'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  // driver: present one beat and hold it until accepted
  task automatic send(input logic [DW-1:0] d, input int m, input int s, input bit r,
                      input logic [QW-1:0] e);
    int budget;
    in_valid = 1'b1;
    in_data = d;
    cfg_mult = MULT_W'(m);
    cfg_shift = SHIFT_W'(s);
    cfg_relu_en = r;
    cur_exp = e;
    budget = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      budget++;
      if (budget > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=in_ready_low required=accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [DW-1:0] d, input int m, input int s, input bit r);
    send(d, m, s, r, model(d, m, s, r));
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) break;
      budget++;
      if (budget > 300) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        exp_q.delete();
        break;
      end
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; sat_clr = 1'b1;
    @(posedge clk); #1; sat_clr = 1'b0;
  endtask

  typedef struct packed {
    logic [DW-1:0]      din;
    logic [MULT_W-1:0]  mult;
    logic [SHIFT_W-1:0] shift;
    logic               relu;
    logic [QW-1:0]      dexp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int seen0;
    logic [DW-1:0] rd;
    int rm, rs;
    bit rr;

    tbl[0] = '{pack_i(100, -50, 1000, 0), 16'd1, 6'd2, 1'b1, pack_o(25, 0, 250, 0)};
    tbl[1] = '{pack_i(70000, -70000, 127, -128), 16'd1, 6'd0, 1'b0, pack_o(127, -128, 127, -128)};
    tbl[2] = '{pack_i(6, -6, 0, 0), 16'd1, 6'd2, 1'b0, pack_o(RND ? 2 : 1, -2, 0, 0)};
    tbl[3] = '{pack_i(64, 64, 64, 64), 16'd1, 6'd0, 1'b0, pack_o(64, 64, 64, 64)};
    tbl[4] = '{pack_i(64, 64, 64, 64), 16'd1, 6'd4, 1'b0, pack_o(4, 4, 4, 4)};
    tbl[5] = '{pack_i(32'h7fffffff, 32'h80000000, 5, -5), 16'd0, 6'd0, 1'b0, pack_o(0, 0, 0, 0)};
    tbl[6] = '{pack_i(200, 300, -7, 255), 16'd1, 6'd0, 1'b1, pack_o(200, 255, 0, 255)};
    tbl[7] = '{pack_i(1000, -1000, 12345, -12345), 16'd300, 6'd12, 1'b0,
               pack_o(73, RND ? -73 : -74, 127, -128)};

    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_data", 128'(out_data), 128'(0));
    chk("reset_sat_flags", 128'(sat_flags), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));

    // table vectors, back-to-back with out_ready high
    for (int i = 0; i < 8; i++) send(tbl[i].din, int'(tbl[i].mult), int'(tbl[i].shift), tbl[i].relu, tbl[i].dexp);
    drain();

    // saturation flags: set, clear, set-wins, and mult=0 flags nothing
    pulse_clr();
    #1 chk("sat_after_clr", 128'(sat_flags), 128'(0));
    send(tbl[1].din, 1, 0, 1'b0, tbl[1].dexp);
    drain();
    chk("sat_flags_set", 128'(sat_flags), 128'(4'b0011));
    pulse_clr();
    #1 chk("sat_flags_cleared", 128'(sat_flags), 128'(0));
    send(tbl[5].din, 0, 0, 1'b0, tbl[5].dexp);
    drain();
    chk("sat_mult0_none", 128'(sat_flags), 128'(0));
    sat_clr = 1'b1;
    send(pack_i(-1, 5, -9000, 9000), 1, 0, 1'b0, pack_o(-1, 5, -128, 127));
    drain();
    chk("sat_set_wins_clr", 128'(sat_flags), 128'(4'b1100));
    sat_clr = 1'b0;

    // backpressure: 10 incrementing beats, out_ready pattern 1,0,0,1
    phase = 0;
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) send_m(pack_i(4*i, 4*i+1, 4*i+2, 4*i+3), 1, 0, 1'b0);
    drain();
    rdy_mode = 0;

    // reset mid-stream with 3 beats in flight
    rdy_mode = 3;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_m(pack_i(10+i, 20+i, 30+i, 40+i), 1, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    exp_q.delete();
    rst = 1'b0;
    rdy_mode = 0;
    seen0 = seen;
    repeat (10) @(posedge clk);
    #2 chk("midrst_no_stale_beats", 128'(seen - seen0), 128'(0));

    // randomized beats, random gaps and random out_ready
    rdy_mode = 2;
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < LANES; i++)
        rd[i*IN_W +: IN_W] = IN_W'($signed($urandom) >>> $urandom_range(0, 31));
      rm = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) rm = int'($urandom_range(0, 4));
      rs = int'($urandom_range(0, IN_W + MULT_W - 1));
      rr = 1'($urandom_range(0, 1));
      send_m(rd, rm, rs, rr);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_vec.md
Name: ppu_vec

Overview:
- Multi-lane, pipelined post-processing unit for the int8 accelerator datapath.
- Takes LANES signed 32-bit accumulator results per beat and applies optional ReLU. Requantizes each lane by a fixed-point multiply plus arithmetic right shift, which replaces the integer divider. Saturates each lane to OUT_W bits.
- Sits between the PE-array accumulator drain and the output SRAM writer, with full valid/ready backpressure on both sides.

Parameters:
- LANES, 4, number of parallel channels per beat.
- IN_W, 32, signed accumulator width per lane.
- OUT_W, 8, quantized output width per lane.
- MULT_W, 16, unsigned requant multiplier width.
- SHIFT_W, 6, requant shift amount width; legal shift range is 0..IN_W+MULT_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  LANES*IN_W  lane i occupies bits [i*IN_W +: IN_W].
- cfg_mult  in  MULT_W  requant multiplier; sampled with each accepted beat.
- cfg_shift  in  SHIFT_W  arithmetic right shift; sampled with each accepted beat.
- cfg_relu_en  in  1  1 = ReLU plus unsigned output; 0 = signed output; sampled with each accepted beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  LANES*OUT_W  lane i occupies bits [i*OUT_W +: OUT_W].
- sat_flags  out  LANES  sticky per-lane saturation indicator.
- sat_clr  in  1  clears sat_flags.

Behaviour:
- Pipeline has 3 registered stages (S1, S2, S3), each with its own valid bit. Latency is 3 cycles from input accept to out_valid with no stall.
  - S1: ReLU. If relu_en and lane < 0, lane becomes 0; otherwise pass through. The cfg fields are registered alongside the data.
  - S2: product = S1 lane (signed IN_W) * {1'b0, mult} (signed), producing a full IN_W+MULT_W+1 bit result with no truncation.
  - S3: product >>> shift (arithmetic), then saturate per lane:
    - relu_en = 1: clamp to [0, 2^OUT_W-1].
    - relu_en = 0: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Flow control:
  - Stage k advances when it is empty or the stage downstream of it advances.
  - S3 advances when out_ready is high or S3 is empty.
  - in_ready = !S1_valid || S1_advance. This is combinational through the stages; no skid buffer is used.
  - Full throughput is 1 beat/cycle when out_ready is held high.
- While out_valid is high and out_ready is low, out_data and out_valid hold stable. Valid never drops without a handshake.
- Bubbles are allowed: when in_valid is low, the freed stage empties and out_valid drops after the bubble reaches S3.
- cfg_* are captured per beat, so config may change on every beat without corrupting beats already in flight.
- sat_flags[i]:
  - Set when lane i is clamped in a beat that is accepted at the output handshake.
  - If sat_clr and a set event occur in the same cycle, the set wins.
  - sat_clr otherwise clears all flags on the next edge.
- Reset behaviour:
  - All stage valids = 0, out_valid = 0, out_data = 0, sat_flags = 0.
  - in_ready = 1 on the first cycle after reset.
  - A reset asserted mid-stream discards all in-flight beats; none are emitted.
- Shift of 0 means no shift. Shifts of IN_W+MULT_W or more are illegal; the output is don't-care and only simulation asserts it.
- mult = 0 yields 0 on every lane, with no saturation flagged.

Optional Feature:
- Macro: PPU_ROUND_EN.
- Defined: round half away from zero in S3 before the shift.
  - When shift > 0, add 2^(shift-1) to a non-negative product, or add 2^(shift-1)-1 to a negative product, then apply the arithmetic shift.
  - Rounding happens before saturation.
- Not defined: truncation, i.e. floor via the arithmetic shift. Latency and handshake are identical in both cases.

Decomposition:
- Package ppu_pkg holds:
  - Localparams PROD_W = IN_W+MULT_W+1 and the saturation bounds.
  - The typedef ppu_cfg_t {mult, shift, relu_en} carried through the pipe.
  - A function sat_clamp(value, relu_en) returning OUT_W bits plus a saturation bit.
- One natural sub-module, ppu_lane, holds the per-lane datapath (relu, multiply, shift, round, clamp) with stage enables from the parent. The parent holds the valid/ready control, generates LANES instances, and owns sat_flags.

Test Plan:
- Basic: lane values {100, -50, 1000, 0}, mult = 1, shift = 2, relu_en = 1, out_ready = 1 -> after 3 cycles out_data lanes = {25, 0, 250, 0}, sat_flags = 0.
- Saturation: lanes {70000, -70000, 127, -128}, mult = 1, shift = 0, relu_en = 0 -> {127, -128, 127, -128}; sat_flags = 4'b0011; then sat_clr -> 4'b0000.
- Rounding, 1 lane: value 6, mult = 1, shift = 2:
  - With PPU_ROUND_EN defined -> 2.
  - Without it -> 1.
  - Value -6, relu_en = 0: with the macro -> -2; without it -> -2 (floor).
- Backpressure: stream 10 beats with incrementing values while out_ready toggles 1,0,0,1 -> all 10 beats appear in order, with no loss or duplication; out_data is stable while stalled; in_ready is low whenever the pipe is full and stalled.
- Per-beat config: beat A with shift = 0, beat B with shift = 4, same data 64 -> outputs 64 then 4, back-to-back.
- Reset mid-stream: reset asserted while 3 beats are in flight -> out_valid = 0 the next cycle, no stale beat is emitted afterward, and in_ready = 1.
